// File: rtl/mem_burst_pkg.sv
// Shared types and default sizing for the mem_burst_ctrl burst controller.
// Holds the FSM state encoding and the memory index-width helper.
package mem_burst_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_DATA
    } state_e;

    // Bits needed to index DEPTH words; a one-word memory still gets one bit.
    function automatic int mem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int MEM_IDX_W = mem_idx_w(DEPTH_DEF);

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Host command/data streams plus the memory pin bundle of mem_burst_ctrl.
// slave = controller view, master = host/memory view.
interface mem_burst_ctrl_if #(
    parameter int WIDTH      = mem_burst_pkg::WIDTH_DEF,
    parameter int ADDR_WIDTH = mem_burst_pkg::ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = mem_burst_pkg::LEN_WIDTH_DEF
);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_wr_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [LEN_WIDTH-1:0]  req_len_i;

    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [WIDTH-1:0]      wr_data_i;

    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [WIDTH-1:0]      rd_data_o;
    logic                  rd_last_o;

    logic                  done_o;
    logic                  err_o;

    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wdata_o;
    logic                  mem_wr_en_o;
    logic                  mem_rd_en_o;
    logic [WIDTH-1:0]      mem_rdata_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_len_i,
        input  wr_valid_i, wr_data_i, rd_ready_i, mem_rdata_i,
        output req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o,
        output done_o, err_o, mem_addr_o, mem_wdata_o, mem_wr_en_o, mem_rd_en_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_len_i,
        output wr_valid_i, wr_data_i, rd_ready_i, mem_rdata_i,
        input  req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, rd_last_o,
        input  done_o, err_o, mem_addr_o, mem_wdata_o, mem_wr_en_o, mem_rd_en_o
    );

endinterface

// File: rtl/mem_burst_addr_gen.sv
// Burst address/beat counter: loads the start word, steps modulo DEPTH,
// counts remaining beats and flags the final beat.
module mem_burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    localparam int IDX_W     = mem_idx_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [IDX_W-1:0]      load_addr_i,
    input  logic [LEN_WIDTH-1:0]  load_len_i,
    input  logic                  inc_addr_i,
    input  logic                  dec_cnt_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [IDX_W-1:0]     cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        if (load_i) begin
            cur_addr_d   = load_addr_i;
            beats_left_d = load_len_i;
        end else begin
            // Power-of-two DEPTH: natural overflow of the index is the modulo wrap.
            if (inc_addr_i) cur_addr_d = cur_addr_q + IDX_W'(1);
            if (dec_cnt_i && beats_left_q != '0) beats_left_d = beats_left_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
        if (rst_i) begin
            cur_addr_q   <= '0;
            beats_left_q <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign addr_o = ADDR_WIDTH'(cur_addr_q);
    assign last_o = (beats_left_q == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst front-end for a single-port memory with a registered, hold-when-idle read port.
// Optional: define MEM_BURST_RANGE_CHECK_EN to reject bursts that run past DEPTH.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_burst_ctrl_if.slave  bus
);

    localparam int IDX_W = mem_idx_w(DEPTH);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    logic                  ag_load, ag_inc, ag_dec, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  wr_en, rd_en;
    logic                  cmd_ok;

`ifdef MEM_BURST_RANGE_CHECK_EN
    logic [ADDR_WIDTH:0] end_addr;
    assign end_addr = {1'b0, bus.req_addr_i} + (ADDR_WIDTH + 1)'(bus.req_len_i);
    assign cmd_ok   = (bus.req_addr_i < ADDR_WIDTH'(DEPTH)) &&
                      (end_addr < (ADDR_WIDTH + 1)'(DEPTH));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr_i[ADDR_WIDTH-1:IDX_W];
    assign cmd_ok         = 1'b1;
`endif

    mem_burst_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ag_load),
        .load_addr_i (bus.req_addr_i[IDX_W-1:0]),
        .load_len_i  (bus.req_len_i),
        .inc_addr_i  (ag_inc),
        .dec_cnt_i   (ag_dec),
        .addr_o      (ag_addr),
        .last_o      (ag_last)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ag_load = 1'b0;
        ag_inc  = 1'b0;
        ag_dec  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (cmd_ok) begin
                        ag_load = 1'b1;
                        state_d = bus.req_wr_i ? WRITE : RD_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.wr_valid_i) begin
                    wr_en  = 1'b1;
                    ag_inc = 1'b1;
                    ag_dec = 1'b1;
                    if (ag_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                // Address moves ahead now; the beat count only drops as beats are consumed.
                rd_en   = 1'b1;
                ag_inc  = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (bus.rd_ready_i) begin
                    if (ag_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_en  = 1'b1;
                        ag_inc = 1'b1;
                        ag_dec = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Reset shares the memory's edge, so enables are masked to keep the reset cycle write-free.
    assign bus.mem_wr_en_o = wr_en & ~rst_i;
    assign bus.mem_rd_en_o = rd_en & ~rst_i;
    assign bus.mem_addr_o  = ag_addr;
    assign bus.mem_wdata_o = bus.wr_data_i;

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.wr_ready_o  = (state_q == WRITE) & ~rst_i;
    assign bus.rd_valid_o  = (state_q == RD_DATA);
    assign bus.rd_data_o   = bus.mem_rdata_i;
    assign bus.rd_last_o   = (state_q == RD_DATA) & ag_last;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural 16x16 memory
// (registered read, holds rdata while idle, cleared by reset).
module tb_mem_burst_ctrl;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [15:0] mem_arr [DEPTH];
    logic [15:0] mem_rdata;
    logic [15:0] ref_mem [DEPTH];

    mem_burst_ctrl_if bus ();

    mem_burst_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (bus.mem_wr_en_o) mem_arr[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
            if (bus.mem_rd_en_o) mem_rdata <= mem_arr[bus.mem_addr_o[3:0]];
        end
    end
    assign bus.mem_rdata_i = mem_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered and left just after a rising edge; the chained form returns in the done cycle.
    task automatic burst_write(input int addr, input int len, input logic [15:0] base,
                               input int gap_beat, input bit chain);
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = 1'b1;
        bus.req_addr_i  = 16'(addr);
        bus.req_len_i   = 8'(len);
        @(negedge clk);
        check("wr_cmd_ready", bus.req_ready_o, 1);
        check("wr_cmd_en", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == gap_beat) begin
                bus.wr_valid_i = 1'b0;
                @(negedge clk);
                check("wr_gap_ready", bus.wr_ready_o, 1);
                check("wr_gap_en", bus.mem_wr_en_o, 0);
                @(posedge clk); #1;
            end
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = base + 16'(i);
            @(negedge clk);
            check("wr_en", bus.mem_wr_en_o, 1);
            check("wr_addr", bus.mem_addr_o, (addr + i) % DEPTH);
            check("wr_data", bus.mem_wdata_o, base + 16'(i));
            check("wr_no_rd", bus.mem_rd_en_o, 0);
            check("wr_busy", bus.req_ready_o, 0);
            ref_mem[(addr + i) % DEPTH] = base + 16'(i);
            @(posedge clk); #1;
        end
        bus.wr_valid_i = 1'b0;
        if (!chain) begin
            @(negedge clk);
            check("wr_done", bus.done_o, 1);
            check("wr_done_idle", bus.req_ready_o, 1);
            check("wr_done_en", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("wr_done_once", bus.done_o, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic burst_read(input int addr, input int len, input int stall_beat,
                              input int stall_cycles, input bit prev_done);
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = 1'b0;
        bus.req_addr_i  = 16'(addr);
        bus.req_len_i   = 8'(len);
        bus.rd_ready_i  = 1'b1;
        @(negedge clk);
        check("rd_cmd_ready", bus.req_ready_o, 1);
        check("rd_prev_done", bus.done_o, prev_done);
        check("rd_cmd_en", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("rd_issue_en", bus.mem_rd_en_o, 1);
        check("rd_issue_addr", bus.mem_addr_o, addr % DEPTH);
        check("rd_issue_valid", bus.rd_valid_o, 0);
        @(posedge clk); #1;
        for (int i = 0; i <= len; i++) begin
            for (int s = 0; s < ((i == stall_beat) ? stall_cycles : 0); s++) begin
                bus.rd_ready_i = 1'b0;
                @(negedge clk);
                check("rd_stall_valid", bus.rd_valid_o, 1);
                check("rd_stall_data", bus.rd_data_o, ref_mem[(addr + i) % DEPTH]);
                check("rd_stall_en", bus.mem_rd_en_o, 0);
                @(posedge clk); #1;
            end
            bus.rd_ready_i = 1'b1;
            @(negedge clk);
            check("rd_valid", bus.rd_valid_o, 1);
            check("rd_data", bus.rd_data_o, ref_mem[(addr + i) % DEPTH]);
            check("rd_last", bus.rd_last_o, (i == len) ? 1 : 0);
            check("rd_en", bus.mem_rd_en_o, (i != len) ? 1 : 0);
            check("rd_no_wr", bus.mem_wr_en_o, 0);
            if (i != len) check("rd_addr", bus.mem_addr_o, (addr + i + 1) % DEPTH);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rd_done", bus.done_o, 1);
        check("rd_done_valid", bus.rd_valid_o, 0);
        check("rd_no_err", bus.err_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_wr_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_len_i   = '0;
        bus.wr_valid_i  = 1'b0;
        bus.wr_data_i   = '0;
        bus.rd_ready_i  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready_o, 1);
        check("rst_enables", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
        check("rst_done_err", {bus.done_o, bus.err_o}, 0);
        check("rst_valid_ready", {bus.rd_valid_o, bus.wr_ready_o}, 0);
        check("rst_addr", bus.mem_addr_o, 0);
        @(posedge clk); #1;

        // Write A0..A3 to 2..5, then read back in the done cycle.
        burst_write(2, 3, 16'h00A0, -1, 1'b1);
        burst_read(2, 3, -1, 0, 1'b1);

        // Backpressure on the second beat for three cycles.
        burst_read(2, 3, 1, 3, 1'b0);

        // Write with an idle beat, then a one-beat read.
        burst_write(8, 1, 16'h0C00, 1, 1'b0);
        burst_read(9, 0, -1, 0, 1'b0);

`ifdef MEM_BURST_RANGE_CHECK_EN
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = 1'b1;
        bus.req_addr_i  = 16'd14;
        bus.req_len_i   = 8'd3;
        @(negedge clk);
        check("rng_cmd_ready", bus.req_ready_o, 1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.wr_valid_i  = 1'b1;
        @(negedge clk);
        check("rng_err", bus.err_o, 1);
        check("rng_idle", bus.req_ready_o, 1);
        check("rng_en", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
        check("rng_no_done", bus.done_o, 0);
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
        @(negedge clk);
        check("rng_err_once", bus.err_o, 0);
        @(posedge clk); #1;
`else
        burst_write(14, 3, 16'h0E00, -1, 1'b0);
        burst_read(14, 3, -1, 0, 1'b0);
`endif

        // Reset during the second beat of an 8-beat write.
        bus.req_valid_i = 1'b1;
        bus.req_wr_i    = 1'b1;
        bus.req_addr_i  = 16'd0;
        bus.req_len_i   = 8'd7;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.wr_valid_i  = 1'b1;
        bus.wr_data_i   = 16'h5500;
        @(posedge clk); #1;
        bus.wr_data_i = 16'h5501;
        rst = 1'b1;
        @(negedge clk);
        check("rstb_no_wr", bus.mem_wr_en_o, 0);
        check("rstb_no_rd", bus.mem_rd_en_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstb_idle", bus.req_ready_o, 1);
        check("rstb_no_done", bus.done_o, 0);
        check("rstb_wr_ready", bus.wr_ready_o, 0);
        check("rstb_en", {bus.mem_wr_en_o, bus.mem_rd_en_o}, 0);
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        burst_read(0, 7, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Front-door burst access controller sitting directly upstream of the single-port 16-bit memory; it owns the memory's addr/wdata/wr_en/rd_en pins.
- Converts one burst command (start address, beat count, direction) into per-cycle memory accesses.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream with last marker.
- Exploits the memory's registered, hold-when-idle read port to sustain one beat per cycle under backpressure.

Parameters:
- WIDTH, 16, data width; equals memory WIDTH.
- DEPTH, 16, memory words; must be a power of two.
- ADDR_WIDTH, 16, address width; equals memory ADDR_WIDTH.
- LEN_WIDTH, 8, burst length field width; beats = req_len_i + 1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset; shared with the memory.
- req_valid_i  in  1  burst command valid.
- req_ready_o  out  1  controller idle and accepting a command.
- req_wr_i  in  1  1 = write burst, 0 = read burst.
- req_addr_i  in  ADDR_WIDTH  start word address.
- req_len_i  in  LEN_WIDTH  beats minus one.
- wr_valid_i  in  1  write beat valid.
- wr_ready_o  out  1  write beat accepted this cycle.
- wr_data_i  in  WIDTH  write beat data.
- rd_valid_o  out  1  read beat valid.
- rd_ready_i  in  1  downstream accepts read beat.
- rd_data_o  out  WIDTH  read beat data.
- rd_last_o  out  1  final beat of the read burst.
- done_o  out  1  one-cycle pulse after burst completion.
- err_o  out  1  one-cycle pulse on rejected command; tied 0 without the optional feature.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wdata_o  out  WIDTH  to memory wdata_i.
- mem_wr_en_o  out  1  to memory wr_en_i.
- mem_rd_en_o  out  1  to memory rd_en_i.
- mem_rdata_i  in  WIDTH  from memory rdata_o.

Behaviour:
- States: IDLE, WRITE, RD_ISSUE, RD_DATA.
- Registers: cur_addr, beats_left, done_q, err_q.
- Reset: state = IDLE, counters = 0, done_o/err_o = 0, mem_wr_en_o/mem_rd_en_o = 0.
- Reset mid-burst: the burst is abandoned, there is no done_o, and no enable is asserted in the reset cycle.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture addr and len, then go to WRITE (req_wr_i = 1) or RD_ISSUE.
  - No memory enables in IDLE.
- Address: mem_addr_o = cur_addr, with upper bits above log2(DEPTH) forced to 0. cur_addr increments modulo DEPTH, so 15 wraps to 0 at the default.
- WRITE:
  - wr_ready_o = 1.
  - On wr_valid_i: mem_wr_en_o = 1 and mem_wdata_o = wr_data_i, both combinational in the same cycle; the memory captures at that edge.
  - cur_addr increments and beats_left decrements.
  - After the beat with beats_left = 0: go to IDLE, done_o pulses next cycle.
  - wr_valid_i low inserts an idle cycle with no enable.
- RD_ISSUE: mem_rd_en_o = 1 for one cycle, then go to RD_DATA.
- RD_DATA:
  - rd_valid_o = 1 and rd_data_o = mem_rdata_i (pass-through; the memory holds rdata while rd_en is low).
  - rd_last_o = (beats_left = 0).
  - rd_ready_i = 0: hold, no enable.
  - rd_ready_i = 1 and not last: mem_rd_en_o = 1 at the next address in the same cycle; next cycle shows the new word.
  - rd_ready_i = 1 and last: go to IDLE, done_o pulses next cycle.
- Read latency: first rd_valid_o occurs 2 cycles after command acceptance. Steady state is 1 beat per cycle.
- Exclusivity: mem_wr_en_o and mem_rd_en_o are never high together.
- req_ready_o = 0 outside IDLE; a new command is accepted the cycle done_o pulses.
- Zero-length (req_len_i = 0) means one beat.

Optional Feature:
- Macro: MEM_BURST_RANGE_CHECK_EN.
- Defined:
  - A command with req_addr_i >= DEPTH or req_addr_i + req_len_i >= DEPTH is accepted but not executed.
  - State stays IDLE, err_o pulses next cycle, no done_o, no memory enable.
- Undefined:
  - err_o is tied 0 and addresses wrap modulo DEPTH as above.

Decomposition:
- Package mem_burst_pkg:
  - state enum (IDLE, WRITE, RD_ISSUE, RD_DATA);
  - MEM_IDX_W = $clog2(DEPTH) helper;
  - default width constants.
- Sub-module mem_burst_addr_gen: load, increment, modulo-DEPTH wrap, beats_left counter, and last flag. Everything else stays in the top FSM.

Test Plan:
- Write burst: addr 2, len 3, data A0..A3, wr_valid_i held high → 4 consecutive mem_wr_en_o at addresses 2..5, done_o pulses 1 cycle after the last beat.
- Read back: addr 2, len 3, rd_ready_i = 1 → rd_data_o = A0..A3 on 4 consecutive cycles starting 2 cycles after accept, rd_last_o only on A3.
- Backpressure: same read with rd_ready_i low on beat 2 for 3 cycles → rd_data_o holds A1, no mem_rd_en_o during stall, no beat lost or duplicated.
- Wrap (feature off): write addr 14, len 3 → accesses at 14, 15, 0, 1.
- Range check (feature on): addr 14, len 3 → err_o pulse, zero memory enables, req_ready_o stays 1.
- Reset mid-burst: rst_i high during beat 2 of an 8-beat write → next cycle state IDLE, all enables 0, no done_o, memory contents zeroed.
